// File: rtl/alu_rs.sv
// ALU reservation station.
// Holds up to RS_DEPTH dispatched ALU instructions, captures missing operands
// from the ALU and load/store result buses, and issues the lowest-index entry
// whose operands are both available, one per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   clear               synchronous flush, drops every entry
//   disp*               dispatch strobe and instruction fields
//   aluCdb*, lsCdb*     result broadcasts (ALU bus has priority on equal tags)
//   rsFull              all entries busy (combinational from state)
//   ALUworkEn           registered issue pulse
//   operandO/T, wrtTag, wrtName, opCode, instAddr
//                       registered issued-instruction fields, zero when idle
module alu_rs #(
  parameter int RS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        dispEn,
  input  logic [5:0]  dispOp,
  input  logic [31:0] dispValO,
  input  logic [31:0] dispValT,
  input  logic [3:0]  dispTagO,
  input  logic [3:0]  dispTagT,
  input  logic        dispRdyO,
  input  logic        dispRdyT,
  input  logic [3:0]  dispWrtTag,
  input  logic [4:0]  dispWrtName,
  input  logic [31:0] dispAddr,
  input  logic        aluCdbEn,
  input  logic [3:0]  aluCdbTag,
  input  logic [31:0] aluCdbData,
  input  logic        lsCdbEn,
  input  logic [3:0]  lsCdbTag,
  input  logic [31:0] lsCdbData,
  output logic        rsFull,
  output logic        ALUworkEn,
  output logic [31:0] operandO,
  output logic [31:0] operandT,
  output logic [3:0]  wrtTag,
  output logic [4:0]  wrtName,
  output logic [5:0]  opCode,
  output logic [31:0] instAddr
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry storage. Only busy is control state; the rest is payload that is
  // meaningless while the entry is free.
  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] ent_rdy_o;
  logic [RS_DEPTH-1:0] ent_rdy_t;
  logic [5:0]          ent_op     [RS_DEPTH];
  logic [31:0]         ent_val_o  [RS_DEPTH];
  logic [31:0]         ent_val_t  [RS_DEPTH];
  logic [3:0]          ent_tag_o  [RS_DEPTH];
  logic [3:0]          ent_tag_t  [RS_DEPTH];
  logic [3:0]          ent_wtag   [RS_DEPTH];
  logic [4:0]          ent_wname  [RS_DEPTH];
  logic [31:0]         ent_addr   [RS_DEPTH];

  logic             vld_p1;
  logic [31:0]      opnd_o_p1;
  logic [31:0]      opnd_t_p1;
  logic [3:0]       wtag_p1;
  logic [4:0]       wname_p1;
  logic [5:0]       op_p1;
  logic [31:0]      addr_p1;

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             disp_go;
  logic [32:0]      byp_o;
  logic [32:0]      byp_t;
  logic [32:0]      wk_o [RS_DEPTH];
  logic [32:0]      wk_t [RS_DEPTH];

  // Returns {hit, data} for a producer tag; the ALU bus wins when both match.
  function automatic logic [32:0] cdb_match(input logic [3:0] tag);
    if (aluCdbEn && (aluCdbTag == tag)) return {1'b1, aluCdbData};
    if (lsCdbEn && (lsCdbTag == tag))   return {1'b1, lsCdbData};
    return 33'd0;
  endfunction

  assign rsFull  = &busy;
  assign disp_go = dispEn && !rsFull && !clear;

  // Stage p0: select from registered state, free-slot search, CDB matching
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    // Descending scan so the last hit is the lowest index.
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (busy[i] && ent_rdy_o[i] && ent_rdy_t[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
    byp_o = dispRdyO ? {1'b1, dispValO} : cdb_match(dispTagO);
    byp_t = dispRdyT ? {1'b1, dispValT} : cdb_match(dispTagT);
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk_o[i] = cdb_match(ent_tag_o[i]);
      wk_t[i] = cdb_match(ent_tag_t[i]);
    end
  end

  // Entry payload: dispatch write (with same-cycle bypass) and wakeup capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (disp_go && (free_idx == IDX_W'(i))) begin
        ent_op[i]    <= dispOp;
        ent_tag_o[i] <= dispTagO;
        ent_tag_t[i] <= dispTagT;
        ent_rdy_o[i] <= byp_o[32];
        ent_val_o[i] <= byp_o[31:0];
        ent_rdy_t[i] <= byp_t[32];
        ent_val_t[i] <= byp_t[31:0];
        ent_wtag[i]  <= dispWrtTag;
        ent_wname[i] <= dispWrtName;
        ent_addr[i]  <= dispAddr;
      end else if (busy[i]) begin
        if (!ent_rdy_o[i] && wk_o[i][32]) begin
          ent_rdy_o[i] <= 1'b1;
          ent_val_o[i] <= wk_o[i][31:0];
        end
        if (!ent_rdy_t[i] && wk_t[i][32]) begin
          ent_rdy_t[i] <= 1'b1;
          ent_val_t[i] <= wk_t[i][31:0];
        end
      end
    end
  end

  // Stage p1: busy bookkeeping and registered issue outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      vld_p1    <= 1'b0;
      opnd_o_p1 <= '0;
      opnd_t_p1 <= '0;
      wtag_p1   <= '0;
      wname_p1  <= '0;
      op_p1     <= '0;
      addr_p1   <= '0;
    end else if (clear) begin
      busy      <= '0;
      vld_p1    <= 1'b0;
      opnd_o_p1 <= '0;
      opnd_t_p1 <= '0;
      wtag_p1   <= '0;
      wname_p1  <= '0;
      op_p1     <= '0;
      addr_p1   <= '0;
    end else begin
      // Dispatch targets a free slot and issue a busy one, so they never collide.
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (disp_go && (free_idx == IDX_W'(i)))      busy[i] <= 1'b1;
        else if (sel_vld && (sel_idx == IDX_W'(i)))  busy[i] <= 1'b0;
      end
      vld_p1 <= sel_vld;
      if (sel_vld) begin
        opnd_o_p1 <= ent_val_o[sel_idx];
        opnd_t_p1 <= ent_val_t[sel_idx];
        wtag_p1   <= ent_wtag[sel_idx];
        wname_p1  <= ent_wname[sel_idx];
        op_p1     <= ent_op[sel_idx];
        addr_p1   <= ent_addr[sel_idx];
      end else begin
        opnd_o_p1 <= '0;
        opnd_t_p1 <= '0;
        wtag_p1   <= '0;
        wname_p1  <= '0;
        op_p1     <= '0;
        addr_p1   <= '0;
      end
    end
  end

  assign ALUworkEn = vld_p1;
  assign operandO  = opnd_o_p1;
  assign operandT  = opnd_t_p1;
  assign wrtTag    = wtag_p1;
  assign wrtName   = wname_p1;
  assign opCode    = op_p1;
  assign instAddr  = addr_p1;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst, clear, dispEn, dispRdyO, dispRdyT;
  logic [5:0]  dispOp;
  logic [31:0] dispValO, dispValT, dispAddr;
  logic [3:0]  dispTagO, dispTagT, dispWrtTag;
  logic [4:0]  dispWrtName;
  logic        aluCdbEn, lsCdbEn;
  logic [3:0]  aluCdbTag, lsCdbTag;
  logic [31:0] aluCdbData, lsCdbData;
  logic        rsFull, ALUworkEn;
  logic [31:0] operandO, operandT, instAddr;
  logic [3:0]  wrtTag;
  logic [4:0]  wrtName;
  logic [5:0]  opCode;

  alu_rs #(.RS_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear), .dispEn(dispEn), .dispOp(dispOp),
    .dispValO(dispValO), .dispValT(dispValT), .dispTagO(dispTagO), .dispTagT(dispTagT),
    .dispRdyO(dispRdyO), .dispRdyT(dispRdyT), .dispWrtTag(dispWrtTag),
    .dispWrtName(dispWrtName), .dispAddr(dispAddr),
    .aluCdbEn(aluCdbEn), .aluCdbTag(aluCdbTag), .aluCdbData(aluCdbData),
    .lsCdbEn(lsCdbEn), .lsCdbTag(lsCdbTag), .lsCdbData(lsCdbData),
    .rsFull(rsFull), .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT),
    .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode), .instAddr(instAddr)
  );

  always #5 clk = ~clk;

  // Behavioural model: a table of waiting instructions.
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vo, vt, ad;
    logic [3:0]  to, tt, wt;
    bit          ro, rt;
    logic [4:0]  wn;
  } ent_t;

  ent_t        m [D];
  logic        exp_en;
  logic [31:0] exp_o, exp_t, exp_ad;
  logic [3:0]  exp_wt;
  logic [4:0]  exp_wn;
  logic [5:0]  exp_op;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < D; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // A broadcast result for a tag, ALU bus first.
  function automatic bit bus_value(input logic [3:0] tag, output logic [31:0] v);
    v = 32'd0;
    if (aluCdbEn && aluCdbTag == tag) begin v = aluCdbData; return 1'b1; end
    if (lsCdbEn && lsCdbTag == tag)   begin v = lsCdbData;  return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i].busy = 1'b0;
    {exp_en, exp_o, exp_t, exp_wt, exp_wn, exp_op, exp_ad} = '0;
  endtask

  // Applied right after each rising edge, using the inputs the DUT just sampled.
  task automatic model_step();
    ent_t nxt [D];
    int   pick, slot;
    logic [31:0] v;
    nxt = m;
    {exp_en, exp_o, exp_t, exp_wt, exp_wn, exp_op, exp_ad} = '0;
    if (clear) begin
      for (int i = 0; i < D; i++) nxt[i].busy = 1'b0;
      m = nxt;
      return;
    end
    pick = -1;
    for (int i = 0; i < D; i++)
      if (pick < 0 && m[i].busy && m[i].ro && m[i].rt) pick = i;
    if (pick >= 0) begin
      exp_en = 1'b1; exp_o = m[pick].vo; exp_t = m[pick].vt; exp_wt = m[pick].wt;
      exp_wn = m[pick].wn; exp_op = m[pick].op; exp_ad = m[pick].ad;
      nxt[pick].busy = 1'b0;
    end
    for (int i = 0; i < D; i++) begin
      if (m[i].busy && !m[i].ro && bus_value(m[i].to, v)) begin nxt[i].ro = 1; nxt[i].vo = v; end
      if (m[i].busy && !m[i].rt && bus_value(m[i].tt, v)) begin nxt[i].rt = 1; nxt[i].vt = v; end
    end
    if (dispEn && !model_full()) begin
      slot = -1;
      for (int i = 0; i < D; i++) if (slot < 0 && !m[i].busy) slot = i;
      nxt[slot].busy = 1'b1; nxt[slot].op = dispOp; nxt[slot].to = dispTagO;
      nxt[slot].tt = dispTagT; nxt[slot].wt = dispWrtTag; nxt[slot].wn = dispWrtName;
      nxt[slot].ad = dispAddr;
      nxt[slot].ro = dispRdyO; nxt[slot].vo = dispValO;
      nxt[slot].rt = dispRdyT; nxt[slot].vt = dispValT;
      if (!dispRdyO && bus_value(dispTagO, v)) begin nxt[slot].ro = 1; nxt[slot].vo = v; end
      if (!dispRdyT && bus_value(dispTagT, v)) begin nxt[slot].rt = 1; nxt[slot].vt = v; end
    end
    m = nxt;
  endtask

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ALUworkEn", ALUworkEn, exp_en);
      chk("operandO", operandO, exp_o);
      chk("operandT", operandT, exp_t);
      chk("wrtTag", wrtTag, exp_wt);
      chk("wrtName", wrtName, exp_wn);
      chk("opCode", opCode, exp_op);
      chk("instAddr", instAddr, exp_ad);
      chk("rsFull", rsFull, model_full());
    end
  end

  task automatic idle();
    clear = 0; dispEn = 0; aluCdbEn = 0; lsCdbEn = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vo, input logic ro,
                      input logic [3:0] to, input logic [31:0] vt, input logic rt,
                      input logic [3:0] tt, input logic [3:0] wt, input logic [4:0] wn,
                      input logic [31:0] ad);
    dispEn = 1; dispOp = op; dispValO = vo; dispRdyO = ro; dispTagO = to;
    dispValT = vt; dispRdyT = rt; dispTagT = tt; dispWrtTag = wt; dispWrtName = wn;
    dispAddr = ad;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1; idle();
    dispOp = 0; dispValO = 0; dispValT = 0; dispTagO = 0; dispTagT = 0;
    dispRdyO = 0; dispRdyT = 0; dispWrtTag = 0; dispWrtName = 0; dispAddr = 0;
    aluCdbTag = 0; aluCdbData = 0; lsCdbTag = 0; lsCdbData = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ALUworkEn", ALUworkEn, 0);
    chk("reset rsFull", rsFull, 0);
    chk("reset operandO", operandO, 0);
    rst = 0;
    chk_en = 1;

    // Basic issue latency.
    disp(6'h01, 5, 1, 0, 7, 1, 0, 3, 9, 32'h100);
    cycle();
    idle();
    cycle();
    chk("add en", ALUworkEn, 1);
    chk("add opO", operandO, 5);
    chk("add opT", operandT, 7);
    chk("add wtag", wrtTag, 3);
    chk("add wname", wrtName, 9);
    cycle();
    chk("add pulse end", ALUworkEn, 0);

    // Wakeup from ALU bus; a non-matching tag does nothing.
    disp(6'h02, 0, 0, 4, 8, 1, 0, 5, 1, 32'h104);
    cycle();
    idle();
    cycle();
    aluCdbEn = 1; aluCdbTag = 5; aluCdbData = 32'hdead;
    cycle();
    chk("tag5 no wake", ALUworkEn, 0);
    aluCdbTag = 4; aluCdbData = 32'h1234;
    cycle();
    chk("capture edge no issue", ALUworkEn, 0);
    idle();
    cycle();
    chk("woken en", ALUworkEn, 1);
    chk("woken opO", operandO, 32'h1234);
    cycle();

    // Fill all entries, overflow ignored, freed slot reused.
    for (int i = 0; i < D; i++) begin
      disp(6'h03, 0, 0, 4'(8 + i), 32'h50 + i, 1, 0, 4'(i), 5'(i), 32'h200 + 4 * i);
      cycle();
    end
    chk("full after 8", rsFull, 1);
    disp(6'h04, 32'h99, 1, 0, 32'h98, 1, 0, 15, 31, 32'h300);
    cycle();
    chk("ninth ignored full", rsFull, 1);
    chk("ninth ignored en", ALUworkEn, 0);
    idle();
    aluCdbEn = 1; aluCdbTag = 10; aluCdbData = 32'h2222;
    cycle();
    chk("still full at wake", rsFull, 1);
    idle();
    cycle();
    chk("entry2 en", ALUworkEn, 1);
    chk("entry2 wtag", wrtTag, 2);
    chk("entry2 opO", operandO, 32'h2222);
    chk("not full after issue", rsFull, 0);
    disp(6'h04, 32'h99, 1, 0, 32'h98, 1, 0, 15, 31, 32'h300);
    cycle();
    idle();
    cycle();
    chk("ninth en", ALUworkEn, 1);
    chk("ninth wtag", wrtTag, 15);

    // Two entries ready on the same edge: lower index first.
    aluCdbEn = 1; aluCdbTag = 9; aluCdbData = 32'h11;
    lsCdbEn = 1; lsCdbTag = 14; lsCdbData = 32'h66;
    cycle();
    idle();
    cycle();
    chk("order first", wrtTag, 1);
    chk("order first opO", operandO, 32'h11);
    cycle();
    chk("order second", wrtTag, 6);
    chk("order second opO", operandO, 32'h66);
    cycle();
    chk("order done", ALUworkEn, 0);

    // Dispatch bypass from the load/store bus.
    disp(6'h05, 0, 0, 2, 3, 1, 0, 4'ha, 7, 32'h400);
    lsCdbEn = 1; lsCdbTag = 2; lsCdbData = 32'hbeef;
    cycle();
    idle();
    cycle();
    chk("bypass en", ALUworkEn, 1);
    chk("bypass opO", operandO, 32'hbeef);

    // Both buses carry the same tag: ALU data wins.
    disp(6'h06, 0, 1, 0, 0, 0, 1, 4'hb, 8, 32'h500);
    cycle();
    idle();
    aluCdbEn = 1; aluCdbTag = 1; aluCdbData = 32'haaaa;
    lsCdbEn = 1; lsCdbTag = 1; lsCdbData = 32'hbbbb;
    cycle();
    idle();
    cycle();
    chk("prio en", ALUworkEn, 1);
    chk("prio opT", operandT, 32'haaaa);

    // Flush with a concurrent dispatch.
    clear = 1;
    disp(6'h07, 1, 1, 0, 2, 1, 0, 4'hc, 9, 32'h600);
    cycle();
    chk("clear full", rsFull, 0);
    chk("clear en", ALUworkEn, 0);
    idle();
    cycle();
    chk("clear no issue", ALUworkEn, 0);

    // Asynchronous reset mid-cycle.
    disp(6'h08, 32'h77, 1, 0, 32'h88, 1, 0, 4'hd, 10, 32'h700);
    cycle();
    idle();
    cycle();
    chk("pre-rst en", ALUworkEn, 1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("async rst en", ALUworkEn, 0);
    chk("async rst opO", operandO, 0);
    chk("async rst full", rsFull, 0);
    rst = 0;
    disp(6'h09, 32'h31, 1, 0, 32'h32, 1, 0, 4'he, 11, 32'h800);
    cycle();
    idle();
    cycle();
    chk("post-rst en", ALUworkEn, 1);
    chk("post-rst opO", operandO, 32'h31);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      clear    = ($urandom_range(0, 63) == 0);
      dispEn   = ($urandom_range(0, 9) < 6);
      dispOp   = 6'($urandom);
      dispValO = $urandom; dispValT = $urandom;
      dispRdyO = $urandom_range(0, 1); dispRdyT = $urandom_range(0, 1);
      dispTagO = 4'($urandom); dispTagT = 4'($urandom);
      dispWrtTag = 4'($urandom); dispWrtName = 5'($urandom); dispAddr = $urandom;
      aluCdbEn = ($urandom_range(0, 9) < 5); aluCdbTag = 4'($urandom); aluCdbData = $urandom;
      lsCdbEn  = ($urandom_range(0, 9) < 4); lsCdbTag  = 4'($urandom); lsCdbData  = $urandom;
      cycle();
    end
    idle();
    repeat (12) cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
